pp_capture_ctrl: RTL and testbench
==================================

Name: pp_capture_ctrl

Overview:
Write-domain acquisition sequencer for the packed ping-pong capture BRAM. It takes ADC A/B samples, packs them and generates the BRAM write strobe and half-select address. It detects the trigger, holds pre/post-trigger sample counts, and publishes each completed half-frame to the read domain through a toggle handshake. A half owned by the reader is never overwritten.

Parameters:
W, 14, single-channel sample width (signed)
AW, 10, half-frame address width; frame length N = 2^AW samples
AUTO_TO, 1000000, auto-mode trigger timeout in wr_clk cycles (>=1)

Ports:
wr_clk  in  1  sample clock
wr_rst_n  in  1  asynchronous, active-low reset
adc_a  in  W  channel A sample, signed, valid every cycle
adc_b  in  W  channel B sample, signed, valid every cycle
arm  in  1  one-cycle pulse; starts acquisition from IDLE
stop  in  1  one-cycle pulse; aborts to IDLE, no publish
mode  in  2  00 single, 01 normal, 10 auto, 11 treated as normal
trig_src  in  1  0 = A, 1 = B
trig_edge  in  1  0 = rising, 1 = falling
trig_level  in  W  signed trigger threshold
force_trig  in  1  pulse; trigger immediately if in ARMED
pre_len  in  AW  pre-trigger sample count, 0..N-1
rd_ack_tgl  in  1  toggle from read domain; each edge releases the owned half
wr_en  out  1  BRAM write enable
wr_addr  out  AW+1  {half_idx, offset}
wr_data  out  2W  {A, B} packed, A in MSBs
frame_tgl  out  1  toggles once per published frame
trig_off  out  AW  offset of trigger sample in the published half; stable while owned=1
owned  out  1  a published half is not yet acknowledged
busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; half_idx 0; rd_ack sync flops 0; timeout counter 0.
- Pipeline: adc_a and adc_b register into s_cur, and s_cur into s_prev, every cycle in all states. wr_data = {s_cur_a, s_cur_b}, so wr_data is 1 cycle after the input. wr_en, wr_addr and wr_data are aligned on the same cycle.
- rd_ack_tgl passes through a 2-flop synchronizer. The edge detect (sync2 XOR sync3) clears owned in the following cycle.
- Trigger sample x = trig_src ? B : A, signed compare.
  - rising: s_prev < trig_level && s_cur >= trig_level.
  - falling: s_prev > trig_level && s_cur <= trig_level.
- State machine:
  - IDLE: wr_en = 0. On arm: latch pre_len into pre_q and post_q = N-1-pre_q, set offset = 0, go to PRE. If pre_q = 0, go straight to ARMED.
  - PRE: wr_en = 1, offset++ each cycle. After pre_q writes, go to ARMED.
  - ARMED: wr_en = 1, offset wraps mod N (circular). Timeout counter increments.
    - Trigger on the edge condition, on force_trig, or in auto mode when the counter reaches AUTO_TO-1.
    - On trigger: trig_q = offset of the sample written this cycle, load post counter = post_q, go to POST. If post_q = 0, go to DONE.
  - POST: wr_en = 1, offset wraps mod N. Decrement the counter per write; after post_q writes go to DONE.
  - DONE: wr_en = 0.
    - If owned = 0: toggle frame_tgl, set owned = 1, drive trig_off = trig_q, flip half_idx.
    - Next state: IDLE in single mode; otherwise re-latch pre_len and go to PRE (or ARMED if pre_q = 0).
    - If owned = 1: stay in DONE (WAIT) with no writes until the ack edge, then publish on the next cycle.
- Ack and DONE in the same cycle: the ack has priority. owned clears, and publish happens the following cycle.
- Published frame content: the reader starts at (trig_off - pre_q) mod N and reads N samples.
- stop in any state: next state IDLE, wr_en = 0. The in-progress half is discarded and half_idx is unchanged; owned and frame_tgl are unchanged.
- arm while not IDLE: ignored. force_trig outside ARMED: ignored.
- Simultaneous stop and arm: stop wins.
- Simultaneous edge trigger and force: a single trigger.
- Writes only ever target half_idx. The published half is never written while owned = 1.
- Reset mid-frame: immediate return to reset values; partial data is discarded.

Test Plan:
- AW=4, pre_len=4, rising, level=0, A ramp -8..+7, mode single, arm -> 4 PRE writes; trigger at sample 0 (offset ≥4); 11 POST writes; frame_tgl 0→1; owned=1; half_idx=1; returns to IDLE.
- Same setup, falling edge with B as source, mode normal, no ack -> second frame completes then holds in DONE with wr_en=0, frame_tgl does not toggle again; toggle rd_ack_tgl -> publish 3 cycles later, half_idx back to 0.
- mode auto, AUTO_TO=20, constant input 0 -> trigger at 20th ARMED cycle, frame published; trig_off = offset written on that cycle.
- pre_len=0 and pre_len=15 (N-1) -> ARMED directly / POST skipped (DONE right after trigger); frame span always exactly 16 writes.
- ARMED running 40 cycles with no trigger -> offset wraps 15→0 correctly; force_trig -> trig_off equals the wrapped offset.
- stop mid-POST, simultaneous arm+stop, async reset mid-PRE -> IDLE, wr_en=0 next cycle, no frame_tgl change; after reset all outputs are 0.

Source files
------------

// File: rtl/pp_capture_ctrl.sv
// Write-domain acquisition sequencer for the packed ping-pong capture BRAM: packs A/B
// samples, runs pre/post-trigger capture and hands finished halves to the read domain.
module pp_capture_ctrl #(
  parameter int W       = 14,
  parameter int AW      = 10,
  parameter int AUTO_TO = 1000000
) (
  input  logic            wr_clk,
  input  logic            wr_rst_n,
  input  logic [W-1:0]    adc_a,
  input  logic [W-1:0]    adc_b,
  input  logic            arm,
  input  logic            stop,
  input  logic [1:0]      mode,
  input  logic            trig_src,
  input  logic            trig_edge,
  input  logic [W-1:0]    trig_level,
  input  logic            force_trig,
  input  logic [AW-1:0]   pre_len,
  input  logic            rd_ack_tgl,
  output logic            wr_en,
  output logic [AW:0]     wr_addr,
  output logic [2*W-1:0]  wr_data,
  output logic            frame_tgl,
  output logic [AW-1:0]   trig_off,
  output logic            owned,
  output logic            busy
);

  localparam int            TW       = (AUTO_TO > 1) ? $clog2(AUTO_TO) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(AUTO_TO - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [AW-1:0] CNT_ONE  = AW'(1);
  localparam logic [AW-1:0] CNT_ZERO = AW'(0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t               state_r;
  logic signed [W-1:0]  cur_a_r, cur_b_r, prev_a_r, prev_b_r;
  logic signed [W-1:0]  x_cur_s, x_prev_s, level_s;
  logic [AW-1:0]        offset_r, cnt_r, post_q_r, trig_q_r;
  logic [TW-1:0]        tmo_r;
  logic                 half_idx_r;
  logic                 ack_s1_r, ack_s2_r, ack_s3_r;
  logic                 ack_edge_s, edge_hit_s, fire_s, publish_s, launch_s, single_s;

  // Samples left after the pre-trigger part: N-1-pre.
  function automatic logic [AW-1:0] post_len(input logic [AW-1:0] pre);
    return {AW{1'b1}} - pre;
  endfunction

  assign level_s    = trig_level;
  assign wr_data    = {cur_a_r, cur_b_r};
  assign wr_addr    = {half_idx_r, offset_r};
  assign ack_edge_s = ack_s2_r ^ ack_s3_r;
  assign single_s   = (mode == 2'b00);
  assign fire_s     = edge_hit_s || force_trig || ((mode == 2'b10) && (tmo_r == TMO_LAST));
  // A pending ack edge defers the publish by one cycle so owned never sees set and clear together.
  assign publish_s  = (state_r == DONE) && !owned && !ack_edge_s;
  assign launch_s   = !stop && (((state_r == IDLE) && arm) || (publish_s && !single_s));

  // Sample pipeline: current and previous A/B samples, running in every state.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      cur_a_r  <= '0;
      cur_b_r  <= '0;
      prev_a_r <= '0;
      prev_b_r <= '0;
    end else begin
      cur_a_r  <= adc_a;
      cur_b_r  <= adc_b;
      prev_a_r <= cur_a_r;
      prev_b_r <= cur_b_r;
    end
  end

  // Read-domain acknowledge toggle synchronizer plus edge-detect delay flop.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      ack_s1_r <= 1'b0;
      ack_s2_r <= 1'b0;
      ack_s3_r <= 1'b0;
    end else begin
      ack_s1_r <= rd_ack_tgl;
      ack_s2_r <= ack_s1_r;
      ack_s3_r <= ack_s2_r;
    end
  end

  // Level-crossing detector on the selected channel, signed compare.
  always_comb begin
    x_cur_s    = cur_a_r;
    x_prev_s   = prev_a_r;
    edge_hit_s = 1'b0;
    if (trig_src) begin
      x_cur_s  = cur_b_r;
      x_prev_s = prev_b_r;
    end else begin
      x_cur_s  = cur_a_r;
      x_prev_s = prev_a_r;
    end
    if (trig_edge) begin
      edge_hit_s = (x_prev_s > level_s) && (x_cur_s <= level_s);
    end else begin
      edge_hit_s = (x_prev_s < level_s) && (x_cur_s >= level_s);
    end
  end

  // Acquisition state machine with registered write strobe and publish handshake.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_r    <= IDLE;
      wr_en      <= 1'b0;
      busy       <= 1'b0;
      offset_r   <= '0;
      cnt_r      <= '0;
      post_q_r   <= '0;
      trig_q_r   <= '0;
      tmo_r      <= '0;
      half_idx_r <= 1'b0;
      frame_tgl  <= 1'b0;
      trig_off   <= '0;
      owned      <= 1'b0;
    end else begin
      if (ack_edge_s) begin
        owned <= 1'b0;
      end
      if (stop) begin
        state_r <= IDLE;
        wr_en   <= 1'b0;
        busy    <= 1'b0;
        tmo_r   <= '0;
      end else begin
        case (state_r)
          IDLE: begin
            wr_en <= 1'b0;
            busy  <= 1'b0;
          end
          PRE: begin
            offset_r <= offset_r + CNT_ONE;
            cnt_r    <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
              state_r <= ARMED;
              tmo_r   <= '0;
            end
          end
          ARMED: begin
            offset_r <= offset_r + CNT_ONE;
            if (fire_s) begin
              trig_q_r <= offset_r;
              cnt_r    <= post_q_r;
              tmo_r    <= '0;
              if (post_q_r == CNT_ZERO) begin
                state_r <= DONE;
                wr_en   <= 1'b0;
              end else begin
                state_r <= POST;
              end
            end else if (tmo_r != TMO_LAST) begin
              tmo_r <= tmo_r + TMO_ONE;
            end
          end
          POST: begin
            offset_r <= offset_r + CNT_ONE;
            cnt_r    <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
              state_r <= DONE;
              wr_en   <= 1'b0;
            end
          end
          DONE: begin
            wr_en <= 1'b0;
            if (publish_s) begin
              frame_tgl  <= ~frame_tgl;
              owned      <= 1'b1;
              trig_off   <= trig_q_r;
              half_idx_r <= ~half_idx_r;
              if (single_s) begin
                state_r <= IDLE;
                busy    <= 1'b0;
              end
            end
          end
          default: begin
            state_r <= IDLE;
            wr_en   <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
        // A new frame (from arm, or re-arm after publish) overrides the per-state updates.
        if (launch_s) begin
          post_q_r <= post_len(pre_len);
          cnt_r    <= pre_len;
          offset_r <= '0;
          tmo_r    <= '0;
          wr_en    <= 1'b1;
          busy     <= 1'b1;
          state_r  <= (pre_len == CNT_ZERO) ? ARMED : PRE;
        end
      end
    end
  end

endmodule

// File: tb/tb_pp_capture_ctrl.sv
// Self-checking bench for pp_capture_ctrl: records the input stream, derives each frame's
// trigger from the capture rules and compares published BRAM halves against it.
module tb_pp_capture_ctrl;

  localparam int W = 14, AW = 4, N = 16, AUTO_TO = 20;

  logic                wr_clk, wr_rst_n;
  logic signed [W-1:0] adc_a, adc_b, trig_level;
  logic                arm, stop, trig_src, trig_edge, force_trig, rd_ack_tgl;
  logic [1:0]          mode;
  logic [AW-1:0]       pre_len;
  logic                wr_en, frame_tgl, owned, busy;
  logic [AW:0]         wr_addr;
  logic [2*W-1:0]      wr_data;
  logic [AW-1:0]       trig_off;

  pp_capture_ctrl #(.W(W), .AW(AW), .AUTO_TO(AUTO_TO)) dut (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .adc_a(adc_a), .adc_b(adc_b), .arm(arm),
    .stop(stop), .mode(mode), .trig_src(trig_src), .trig_edge(trig_edge),
    .trig_level(trig_level), .force_trig(force_trig), .pre_len(pre_len),
    .rd_ack_tgl(rd_ack_tgl), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_tgl(frame_tgl), .trig_off(trig_off), .owned(owned), .busy(busy)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, last_pub = -1, force_at = -1, gen_kind = 0, const_val = 0;
  int xa[$], xb[$];
  bit fh[$];
  bit exp_half = 1'b0, last_tgl = 1'b0;
  logic [2*W-1:0] mem [2][N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Writes land in the bench's BRAM image; every written word must be the sample of that edge.
  task automatic observe();
    logic [W-1:0] ea, eb;
    if (frame_tgl !== last_tgl) begin
      last_tgl = frame_tgl;
      exp_half = ~exp_half;
      last_pub = cyc;
    end
    if (wr_en) begin
      ea = W'(xa[cyc]);
      eb = W'(xb[cyc]);
      check("wdata", wr_data, {ea, eb});
      check("whalf", wr_addr[AW], exp_half);
      mem[wr_addr[AW]][wr_addr[AW-1:0]] = wr_data;
    end
  endtask

  task automatic tick();
    int r;
    case (gen_kind)
      0: begin
        r = int'($urandom_range(100)) - 50; adc_a = W'(r);
        r = int'($urandom_range(100)) - 50; adc_b = W'(r);
      end
      1: begin
        adc_a = W'((cyc % 16) - 8);
        r = int'($urandom_range(100)) - 50; adc_b = W'(r);
      end
      default: begin
        adc_a = W'(const_val);
        adc_b = W'(const_val);
      end
    endcase
    force_trig = (cyc == force_at);
    xa.push_back(int'(adc_a));
    xb.push_back(int'(adc_b));
    fh.push_back(force_trig);
    @(posedge wr_clk);
    #1;
    observe();
    cyc++;
  endtask

  // First stream index t >= a (a = first ARMED sample) meeting a trigger rule.
  function automatic int find_trig(int a, int md, bit src, bit edg, int level);
    int p, c;
    for (int t = a; t < cyc - 1; t++) begin
      p = src ? xb[t-1] : xa[t-1];
      c = src ? xb[t] : xa[t];
      if ((edg ? (p > level && c <= level) : (p < level && c >= level)) || fh[t+1] ||
          (md == 2 && t - a == AUTO_TO - 1))
        return t;
    end
    return -1;
  endfunction

  task automatic wait_pub(input int since, input int budget);
    for (int i = 0; i < budget && last_pub < since; i++) tick();
    check("pub_seen", last_pub >= since, 1);
  endtask

  // Frame started with its first write at stream index k; checks trigger offset and content.
  task automatic check_frame(input int k, input int pre, input int md, input bit src,
                             input bit edg, input int level, input bit held);
    int t, toff, idx, s;
    bit h;
    logic [W-1:0] ea, eb;
    t = find_trig(k + pre, md, src, edg, level);
    check("trig_found", t >= 0, 1);
    if (t >= 0) begin
      if (!held) check("pub_time", last_pub, t + (N - 1 - pre) + 2);
      toff = (t - k) % N;
      h = ~exp_half;
      check("trig_off", trig_off, toff);
      check("owned_set", owned, 1);
      for (int i = 0; i < N; i++) begin
        idx = (toff - pre + i + N) % N;
        s = t - pre + i;
        ea = W'(xa[s]);
        eb = W'(xb[s]);
        check("frame", mem[h][idx], {ea, eb});
      end
    end
  endtask

  task automatic release_half();
    rd_ack_tgl = ~rd_ack_tgl;
    repeat (3) tick();
    check("owned_clr", owned, 0);
    tick();
  endtask

  task automatic do_single(input int pre, input bit src, input bit edg, input int level,
                           input int fdel);
    int k;
    if (owned) release_half();
    mode = 2'b00; pre_len = AW'(pre); trig_src = src; trig_edge = edg; trig_level = W'(level);
    k = cyc;
    force_at = (fdel > 0) ? k + fdel : -1;
    arm = 1'b1; tick(); arm = 1'b0;
    wait_pub(k, 200);
    check_frame(k, pre, 0, src, edg, level, 0);
    check("single_idle", busy, 0);
    force_at = -1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_outs"}, {wr_en, wr_addr, wr_data, frame_tgl, trig_off, owned, busy}, 0);
  endtask

  initial begin
    int k, k3, ka, lv;
    bit saved;
    adc_a = '0; adc_b = '0; trig_level = '0; arm = 1'b0; stop = 1'b0; trig_src = 1'b0;
    trig_edge = 1'b0; force_trig = 1'b0; rd_ack_tgl = 1'b0; mode = 2'b00; pre_len = '0;
    wr_rst_n = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    wr_rst_n = 1'b1;
    tick();

    // Ramp on A, rising through 0, single shot.
    gen_kind = 1;
    do_single(4, 0, 0, 0, 0);
    check("s1_tgl", frame_tgl, 1);

    // Normal mode, falling on B, previous half still owned: frame must hold in DONE.
    gen_kind = 0; lv = int'($urandom_range(40)) - 20;
    mode = 2'b01; pre_len = AW'(4); trig_src = 1'b1; trig_edge = 1'b1; trig_level = W'(lv);
    k = cyc; arm = 1'b1; tick(); arm = 1'b0;
    repeat (120) tick();
    check("hold_tgl", frame_tgl, 1);
    check("hold_wr_en", wr_en, 0);
    check("hold_busy", busy, 1);
    rd_ack_tgl = ~rd_ack_tgl; ka = cyc;
    repeat (3) tick();
    check("ack_owned", owned, 0);
    check("ack_tgl_hold", frame_tgl, 1);
    tick();
    check("ack_pub_time", last_pub, ka + 3);
    check_frame(k, 4, 1, 1, 1, lv, 1);
    k3 = last_pub;
    release_half();
    wait_pub(k3 + 1, 200);
    check_frame(k3, 4, 1, 1, 1, lv, 0);
    saved = frame_tgl;
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_tgl", frame_tgl, saved);
    release_half();

    // Auto mode on a flat input: only the timeout can fire.
    gen_kind = 2; const_val = 0;
    repeat (2) tick();
    mode = 2'b10; pre_len = AW'(4); trig_src = 1'b0; trig_edge = 1'b0; trig_level = '0;
    k = cyc; arm = 1'b1; tick(); arm = 1'b0;
    wait_pub(k, 100);
    check_frame(k, 4, 2, 0, 0, 0, 0);
    check("auto_toff", trig_off, 7);
    stop = 1'b1; tick(); stop = 1'b0;
    release_half();

    // Extreme pre-trigger lengths.
    gen_kind = 0;
    do_single(0, 0, 0, 0, 0);
    do_single(N - 1, 1, 1, 5, 0);

    // Long ARMED dwell with no crossing, then a forced trigger after offset wrap.
    gen_kind = 2; const_val = 5;
    do_single(4, 0, 0, 0, 45);
    check("force_toff", trig_off, 12);

    // Simultaneous arm and stop stays idle.
    arm = 1'b1; stop = 1'b1; tick(); arm = 1'b0; stop = 1'b0;
    check("armstop_busy", busy, 0);
    check("armstop_wr_en", wr_en, 0);

    // Stop during POST discards the frame.
    if (owned) release_half();
    saved = frame_tgl;
    mode = 2'b00; pre_len = AW'(4); trig_level = '0;
    k = cyc; force_at = k + 6; arm = 1'b1; tick(); arm = 1'b0;
    repeat (7) tick();
    check("post_active", {busy, wr_en}, 2'b11);
    stop = 1'b1; tick(); stop = 1'b0;
    check("stoppost_idle", {busy, wr_en}, 2'b00);
    repeat (20) tick();
    check("stoppost_nopub", frame_tgl, saved);
    force_at = -1;

    // Asynchronous reset in the middle of PRE (with a half still owned).
    gen_kind = 0;
    do_single(3, 0, 0, 0, 0);
    pre_len = AW'(8); arm = 1'b1; tick(); arm = 1'b0;
    repeat (2) tick();
    #2 wr_rst_n = 1'b0;
    exp_half = 1'b0; last_tgl = 1'b0;
    #1 check_zero("midreset");
    repeat (2) tick();
    wr_rst_n = 1'b1;
    tick();

    // Randomized single-shot frames, some with a forced trigger.
    for (int it = 0; it < 8; it++) begin
      lv = int'($urandom_range(40)) - 20;
      do_single(int'($urandom_range(N - 1)), 1'($urandom_range(1)), 1'($urandom_range(1)), lv,
                ($urandom_range(1) == 1) ? int'($urandom_range(40, 5)) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
